// File: rtl/btn_seq_fsm.sv
// Button-sequence detector: extracts press events from a button vector and matches them
// against a run-time programmable code table, with inter-press timeout and match counting.
module btn_seq_fsm #(
    parameter int unsigned NBTN     = 3,
    parameter int unsigned SEQ_LEN  = 4,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned OUT_MODE = 0,
    parameter logic [SEQ_LEN*NBTN-1:0] SEQ_INIT = {SEQ_LEN{NBTN'(1)}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NBTN:1]              b,
    input  logic                       cfg_we,
    input  logic [$clog2(SEQ_LEN)-1:0] cfg_idx,
    input  logic [NBTN-1:0]            cfg_code,
    output logic                       outp,
    output logic                       busy,
    output logic                       err,
    output logic [7:0]                 match_cnt
);

    localparam int unsigned IW = $clog2(SEQ_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IdxLast = IW'(SEQ_LEN - 1);
    // Timeout fires on the cycle in which tmr would step onto TIMEOUT-1.
    localparam logic [TW-1:0] TmrLast = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StMatch
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [NBTN-1:0] b_q;
    logic            outp_q, outp_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NBTN-1:0] seq_q [SEQ_LEN];

    logic            ev;
    logic [NBTN-1:0] ev_code;
    logic [NBTN-1:0] seq_cur;
    logic            cfg_ok;

    // Press event: rising from all-released to any nonzero code.
    assign ev_code = b;
    assign ev      = (b_q == '0) && (ev_code != '0);
    assign seq_cur = seq_q[idx_q];
    assign cfg_ok  = cfg_we && (state_q == StIdle) && !ev && (32'(cfg_idx) < SEQ_LEN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        err_d   = 1'b0;
        outp_d  = (OUT_MODE == 0) ? 1'b0 : outp_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (ev && (ev_code == seq_q[0])) begin
                    idx_d   = IW'(1);
                    tmr_d   = '0;
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (ev) begin
                    tmr_d = '0;
                    if (ev_code == seq_cur) begin
                        if (idx_q == IdxLast) begin
                            state_d = StMatch;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        // A wrong code that is itself the first code restarts tracking.
                        if (ev_code == seq_q[0]) begin
                            idx_d = IW'(1);
                        end else begin
                            idx_d   = '0;
                            state_d = StIdle;
                        end
                    end
                end else if (tmr_q == TmrLast) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    tmr_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StMatch: begin
                state_d = StIdle;
                idx_d   = '0;
                tmr_d   = '0;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                outp_d = (OUT_MODE == 0) ? 1'b1 : ~outp_q;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tmr_q   <= '0;
            b_q     <= '0;
            outp_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            b_q     <= ev_code;
            outp_q  <= outp_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SEQ_LEN; i++) begin
                seq_q[i] <= SEQ_INIT[i*NBTN +: NBTN];
            end
        end else if (cfg_ok) begin
            seq_q[cfg_idx] <= cfg_code;
        end
    end

    assign outp      = outp_q;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign match_cnt = cnt_q;

    idx_in_range_a: assert property (@(posedge clk) disable iff (!rst_n) idx_q <= IdxLast);

    if (OUT_MODE == 0) begin : g_pulse_chk
        err_outp_excl_a: assert property (@(posedge clk) disable iff (!rst_n) !(err_q && outp_q));
    end

endmodule
